muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Sequences the shared iterative multiply/divide unit for instructions in the Execute stage.
- On a qualified multi-cycle op in E, it issues a start pulse to the unit and holds F, D and E stalled for the op's fixed latency.
- While stalled, it inserts bubbles into M, then releases the instruction with a one-cycle result-valid strobe.
- It also merges the pipeline's load-use stall into the final StallF/StallD/FlushE controls.

Parameters:
- MUL_CYCLES, 4, total stall cycles for a multiply (>=1)
- DIV_CYCLES, 32, total stall cycles for a divide (>=1)
- CNT_W: localparam = $clog2(max(MUL_CYCLES, DIV_CYCLES)+1); not overridable

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- StartMulE  in  1  E-stage instruction is a multi-cycle multiply
- StartDivE  in  1  E-stage instruction is a divide
- CondExE  in  1  E-stage condition passed; op is qualified only when 1
- LDRstallIn  in  1  load-use stall request from hazard detection
- MdStart  out  1  one-cycle start pulse to the mul/div unit
- MdOpDiv  out  1  operation select to unit, valid with MdStart (1 = divide)
- StallF  out  1  fetch stall
- StallD  out  1  decode stall
- StallE  out  1  execute register hold
- FlushM  out  1  insert bubble into E/M register
- FlushE  out  1  insert bubble into D/E register
- ResultValidE  out  1  unit result valid this cycle; E instruction advances
- Busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, DONE. Counter cnt[CNT_W-1:0]. Register opdiv.
- Qualified request: req = (StartMulE | StartDivE) & CondExE, evaluated only in IDLE. Divide has priority when both are set; the op is treated as a divide.
- N = DIV_CYCLES if divide, else MUL_CYCLES.
- IDLE with req, all combinational in the same cycle:
  - MdStart=1, MdOpDiv=StartDivE, MdStall=1.
  - Next state is RUN with cnt<=N-1 and opdiv latched; if N==1, next state is DONE directly.
- IDLE without req: MdStall=0, no state change.
- RUN: MdStall=1 and cnt decrements each cycle. When cnt==1, next state is DONE.
- Total MdStall cycles = N exactly. The unit result must be valid N cycles after MdStart.
- DONE: MdStall=0 and ResultValidE=1. Next state is IDLE.
  - If LDRstallIn=1 in DONE, remain in DONE and hold ResultValidE=1. Defensive only; cannot occur in a legal pipeline.
- In DONE the E instruction still shows StartMulE/StartDivE. This must NOT retrigger, because req is evaluated only in IDLE.
- Outputs:
  - StallF = StallD = MdStall | LDRstallIn
  - StallE = MdStall
  - FlushM = MdStall
  - FlushE = LDRstallIn & ~MdStall (a held E register is never flushed)
  - Busy = (state != IDLE)
- CondExE=0 with StartMulE/StartDivE=1: no start and no stall; the instruction passes as a NOP.
- Reset:
  - While reset=0, state=IDLE, cnt=0, opdiv=0, and every output is forced to 0, including the LDRstallIn pass-through.
  - Reset mid-RUN aborts immediately. After release the block is in IDLE and re-evaluates req.
- All state updates occur on the posedge of clk. The counter never wraps: it is loaded only from IDLE and stops at DONE.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - Adds input port MdDone (1 bit, from the unit).
  - In RUN, MdDone=1 forces next state DONE regardless of cnt. Stall therefore ends after the cycle MdDone is seen.
  - MdDone in IDLE or DONE is ignored.
  - The cnt==1 path remains as a timeout upper bound.
- Undefined: the port is absent and latency is fixed at N.

Test Plan:
- Multiply: CondExE=1, StartMulE=1 at cycle 0 (MUL_CYCLES=4).
  - Cycle 0: MdStart=1 with MdOpDiv=0.
  - Cycles 0-3: StallF/D/E=FlushM=1.
  - Cycle 4: ResultValidE=1 and stalls=0.
  - Cycle 5: Busy=0 and no second MdStart.
- Divide priority: StartMulE=StartDivE=1 → MdOpDiv=1 and 32 stall cycles, then ResultValidE for 1 cycle.
- Condition fail: CondExE=0, StartDivE=1 → MdStart=0, all stalls 0, Busy=0.
- Load-use merge:
  - LDRstallIn=1 in IDLE → StallF=StallD=FlushE=1, StallE=0.
  - LDRstallIn=1 during RUN → FlushE=0, StallE=1.
- Reset mid-op: reset=0 at RUN cycle 2 of a divide → all outputs 0 immediately. After release with StartDivE=1, a fresh MdStart and a 32-cycle sequence follow.
- With MULDIV_EARLY_OUT_EN: divide with MdDone=1 in RUN cycle 5 → ResultValidE on cycle 6, with 6 total stall cycles.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: starts the shared mul/div unit and stalls F/D/E until its result is valid.
// Optional MULDIV_EARLY_OUT_EN adds MdDone so the unit can finish before the fixed latency.
module muldiv_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic StartMulE,
  input  logic StartDivE,
  input  logic CondExE,
  input  logic LDRstallIn,
`ifdef MULDIV_EARLY_OUT_EN
  input  logic MdDone,
`endif
  output logic MdStart,
  output logic MdOpDiv,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic FlushM,
  output logic FlushE,
  output logic ResultValidE,
  output logic Busy
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, n;
  logic opdiv, opdiv_n, req, md_stall, start, valid, early;
  assign req = (StartMulE | StartDivE) & CondExE;
  assign n = StartDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
`ifdef MULDIV_EARLY_OUT_EN
  assign early = MdDone;
`else
  assign early = 1'b0;
`endif
  // req is only looked at in IDLE, so the op still visible in E during DONE never retriggers
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    opdiv_n = opdiv;
    md_stall = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    case (state)
      IDLE: if (req) begin
        start = 1'b1;
        md_stall = 1'b1;
        cnt_n = n - ONE;
        opdiv_n = StartDivE;
        state_n = (n == ONE) ? DONE : RUN;
      end
      RUN: begin
        md_stall = 1'b1;
        cnt_n = cnt - ONE;
        state_n = (cnt == ONE || early) ? DONE : RUN;
      end
      DONE: begin
        valid = 1'b1;
        state_n = LDRstallIn ? DONE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      opdiv <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      opdiv <= opdiv_n;
    end
  end
  // reset also silences the combinational load-use pass-through
  assign MdStart = reset & start;
  assign MdOpDiv = reset & start & StartDivE;
  assign StallF = reset & (md_stall | LDRstallIn);
  assign StallD = reset & (md_stall | LDRstallIn);
  assign StallE = reset & md_stall;
  assign FlushM = reset & md_stall;
  assign FlushE = reset & LDRstallIn & ~md_stall;
  assign ResultValidE = reset & valid;
  assign Busy = reset & (state != IDLE);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer against a cycle-count model.
module tb_muldiv_sequencer;
  localparam int MUL = 4;
  localparam int DIV = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic StartMulE = 1'b0, StartDivE = 1'b0, CondExE = 1'b0, LDRstallIn = 1'b0, MdDone = 1'b0;
  logic MdStart, MdOpDiv, StallF, StallD, StallE, FlushM, FlushE, ResultValidE, Busy;
  int tests = 0, fails = 0, stalls = 0, cyc = 0;
  int k = -1;
  int n_eff = 0;
  bit early_en;
  always #5 clk = ~clk;
  muldiv_sequencer #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset),
    .StartMulE(StartMulE), .StartDivE(StartDivE), .CondExE(CondExE), .LDRstallIn(LDRstallIn),
`ifdef MULDIV_EARLY_OUT_EN
    .MdDone(MdDone),
`endif
    .MdStart(MdStart), .MdOpDiv(MdOpDiv), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushM(FlushM), .FlushE(FlushE), .ResultValidE(ResultValidE), .Busy(Busy)
  );
  function automatic logic [8:0] outs();
    return {MdStart, MdOpDiv, StallF, StallD, StallE, FlushM, FlushE, ResultValidE, Busy};
  endfunction
  task automatic check(input string tag, input logic [8:0] exp);
    tests++;
    assert (outs() === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, outs(), exp);
    end
  endtask
  // k counts cycles since the op started (-1 = idle); the op stalls for nn cycles then shows valid
  task automatic step(input bit m, input bit d, input bit c, input bit l, input bit dn);
    bit rq, st, stall, valid;
    int nn, cur;
    StartMulE = m; StartDivE = d; CondExE = c; LDRstallIn = l; MdDone = dn;
    @(negedge clk);
    rq = (m | d) & c;
    st = (k < 0) && rq;
    nn = (k < 0) ? (d ? DIV : MUL) : n_eff;
    cur = (k >= 0) ? k : (rq ? 0 : -1);
    stall = cur >= 0 && cur < nn;
    valid = cur >= 0 && cur == nn;
    check("step", {st, st & d, stall | l, stall | l, stall, stall, l & ~stall, valid, k >= 0});
    if (StallE) stalls++;
    @(posedge clk);
    cyc++;
    if (st) n_eff = nn;
    if (cur < 0) k = -1;
    else if (valid) k = l ? k : -1;
    else begin
      if (early_en && dn && cur >= 1) n_eff = cur + 1;
      k = cur + 1;
    end
    #1;
  endtask
  task automatic stall_count(input string tag, input int exp);
    tests++;
    assert (stalls === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, stalls, exp);
    end
  endtask
  task automatic async_reset();
    StartDivE = 1'b1; CondExE = 1'b1; LDRstallIn = 1'b1;
    reset = 1'b0;
    #1 check("reset_zero", 9'b0);
    LDRstallIn = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    k = -1;
  endtask
  initial begin
`ifdef MULDIV_EARLY_OUT_EN
    early_en = 1'b1;
`else
    early_en = 1'b0;
`endif
    StartDivE = 1'b1; CondExE = 1'b1; LDRstallIn = 1'b1;
    #1 check("reset_init", 9'b0);
    LDRstallIn = 1'b0; StartDivE = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    stalls = 0;
    repeat (5) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    stall_count("mul_stalls", MUL);
    stalls = 0;
    repeat (DIV + 1) step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    stall_count("div_prio_stalls", DIV);
    repeat (3) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    async_reset();
    stalls = 0;
    repeat (DIV + 1) step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    stall_count("div_after_reset", DIV);
    if (early_en) begin
      stalls = 0;
      repeat (5) step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 1);
      step(0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      stall_count("early_out_stalls", 6);
    end
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    step(0, 0, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
